// File: rtl/fsm_a.sv
// fsm_a: Mealy detector for serial pattern 1101, flag in the cycle of the last bit.
// Define FSM_A_OVERLAP_EN for overlapping detection; otherwise matched bits are not reused.
module fsm_a (
  input  logic CLK,
  input  logic Reset,
  input  logic x_in,
  output logic y_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state_q;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S0;
    end else begin
      case (state_q)
        S0: state_q <= x_in ? S1 : S0;
        S1: state_q <= x_in ? S2 : S0;
        S2: state_q <= x_in ? S2 : S3;
`ifdef FSM_A_OVERLAP_EN
        // the completing 1 doubles as the first bit of the next match
        S3: state_q <= x_in ? S1 : S0;
`else
        S3: state_q <= S0;
`endif
        default: state_q <= S0;
      endcase
    end
  end

  assign y_out = (state_q == S3) & x_in & Reset;

endmodule

// File: tb/tb_fsm_a.sv
// tb_fsm_a: directed and random stimulus for fsm_a.
// Reference model matches the pattern against a short bit history.
module tb_fsm_a;

  logic CLK;
  logic Reset;
  logic x_in;
  logic y_out;

  int n_cmp;
  int n_bad;
  bit hist[$];

  fsm_a dut (
    .CLK   (CLK),
    .Reset (Reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // bits seen since the last reset or (non-overlap) last detection
  task automatic model(input bit r, input bit x, output bit det);
    det = 1'b0;
    if (!r) begin
      hist.delete();
    end else begin
      hist.push_back(x);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4)
        det = hist[0] && hist[1] && !hist[2] && hist[3];
`ifndef FSM_A_OVERLAP_EN
      if (det) hist.delete();
`endif
    end
  endtask

  task automatic step(input string tag, input bit r, input bit x);
    bit exp;
    @(posedge CLK);
    #1;
    Reset = r;
    x_in  = x;
    model(r, x, exp);
    @(negedge CLK);
    chk(tag, y_out, exp);
  endtask

  task automatic seq(input string tag, input logic [15:0] bits,
                     input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, bits[n-1-i]);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b0;
    x_in  = 1'b0;

    step("rst0", 1'b0, 1'b1);
    step("rst1", 1'b0, 1'b0);
    seq("ovl", 16'b1101101, 7);

    step("rst", 1'b0, 1'b0);
    seq("run1", 16'b111101, 6);

    step("rst", 1'b0, 1'b0);
    seq("near", 16'b101001100, 9);

    step("rst", 1'b0, 1'b0);
    seq("mid", 16'b110, 3);
    step("mid_rst", 1'b0, 1'b1);
    step("mid_post", 1'b1, 1'b1);

    step("hold0", 1'b0, 1'b1);
    step("hold1", 1'b0, 1'b0);
    step("hold2", 1'b0, 1'b1);
    seq("after", 16'b1101, 4);

    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 31) != 0);
      step("rand", r, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
